// File: rtl/scan_mux.sv
// Registered N-channel multiplexer with manual select or timed auto-scan.
// Define SCAN_MUX_SKIP_EN to add ch_enable, which lets the scan skip disabled channels.
module scan_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 50000000
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      mode,
  input  logic                      hold,
`ifdef SCAN_MUX_SKIP_EN
  input  logic [CHANNELS-1:0]       ch_enable,
`endif
  output logic [WIDTH-1:0]          data_out,
  output logic [SEL_W-1:0]          cur_ch,
  output logic                      ch_change
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} state_t;

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_next;
  logic [SEL_W-1:0]     ch_next;
  logic [SEL_W-1:0]     scan_ch;
  logic [SEL_W-1:0]     hi_ch;
  logic [SEL_W-1:0]     lo_ch;
  logic                 hi_found;
  logic                 lo_found;
  logic                 sel_ok;
  logic [WIDTH-1:0]     sel_data;
  logic [CHANNELS-1:0]  en;

`ifdef SCAN_MUX_SKIP_EN
  assign en = ch_enable;
`else
  assign en = '1;
`endif

  // State register: tracks mode with one cycle of lag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= MANUAL;
    else         state <= state_next;
  end

  always_comb begin
    state_next = mode ? SCAN : MANUAL;
  end

  // Next scan channel: first enabled channel above cur_ch, else first below it,
  // else stay put (covers "only cur_ch enabled" and "none enabled").
  always_comb begin
    hi_ch    = '0;
    lo_ch    = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    sel_ok   = 1'b0;
    sel_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!hi_found && en[k] && (SEL_W'(k) > cur_ch)) begin
        hi_ch    = SEL_W'(k);
        hi_found = 1'b1;
      end
      if (!lo_found && en[k] && (SEL_W'(k) < cur_ch)) begin
        lo_ch    = SEL_W'(k);
        lo_found = 1'b1;
      end
      if ((sel_in == SEL_W'(k)) && en[k]) sel_ok = 1'b1;
      if (cur_ch == SEL_W'(k)) sel_data = data_in[k*WIDTH +: WIDTH];
    end
    scan_ch = hi_found ? hi_ch : (lo_found ? lo_ch : cur_ch);
  end

  // Priority: hold, then mode change (state_next != state), then dwell wrap.
  always_comb begin
    cnt_next = cnt;
    ch_next  = cur_ch;
    if (!hold) begin
      if (state == MANUAL) begin
        cnt_next = '0;
        if (sel_ok) ch_next = sel_in;
      end else if (state_next != state) begin
        cnt_next = '0;
      end else if (cnt == CNT_LAST) begin
        cnt_next = '0;
        ch_next  = scan_ch;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt       <= '0;
      cur_ch    <= '0;
      ch_change <= 1'b0;
      data_out  <= '0;
    end else begin
      cnt       <= cnt_next;
      cur_ch    <= ch_next;
      ch_change <= (ch_next != cur_ch);
      data_out  <= sel_data;
    end
  end

endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux: a 4-channel DWELL=3 instance and a 3-channel DWELL=1 instance.
// Define SCAN_MUX_SKIP_EN to also exercise the channel-skip feature.
module tb_scan_mux;

  logic        clk;
  logic        resetn;
  logic [31:0] din;
  logic [1:0]  sel;
  logic        mode;
  logic        hold;
  logic [7:0]  dout;
  logic [1:0]  cur;
  logic        chg;

  logic [23:0] din3;
  logic [1:0]  sel3;
  logic        mode3;
  logic        hold3;
  logic [7:0]  dout3;
  logic [1:0]  cur3;
  logic        chg3;

`ifdef SCAN_MUX_SKIP_EN
  logic [3:0]  ch_en;
  logic [2:0]  ch_en3;
`endif

  int checks = 0;
  int errors = 0;

  scan_mux #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .DWELL(3)) dut (
    .clk(clk), .resetn(resetn), .data_in(din), .sel_in(sel), .mode(mode), .hold(hold),
`ifdef SCAN_MUX_SKIP_EN
    .ch_enable(ch_en),
`endif
    .data_out(dout), .cur_ch(cur), .ch_change(chg)
  );

  scan_mux #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .DWELL(1)) dut3 (
    .clk(clk), .resetn(resetn), .data_in(din3), .sel_in(sel3), .mode(mode3), .hold(hold3),
`ifdef SCAN_MUX_SKIP_EN
    .ch_enable(ch_en3),
`endif
    .data_out(dout3), .cur_ch(cur3), .ch_change(chg3)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_main(input string tag, input logic [1:0] e_cur, input logic e_chg);
    chk({tag, ".cur_ch"}, 32'(cur), 32'(e_cur));
    chk({tag, ".ch_change"}, 32'(chg), 32'(e_chg));
  endtask

  logic [7:0] dtab [4];
  logic [1:0] c;
  logic [1:0] seq6 [4];

  initial begin
    dtab[0] = 8'h11; dtab[1] = 8'h22; dtab[2] = 8'h33; dtab[3] = 8'h44;
    resetn = 1'b1;
    din    = {8'h44, 8'h33, 8'h22, 8'h11};
    sel    = 2'd0;
    mode   = 1'b0;
    hold   = 1'b0;
    din3   = {8'h77, 8'h66, 8'h55};
    sel3   = 2'd0;
    mode3  = 1'b0;
    hold3  = 1'b0;
`ifdef SCAN_MUX_SKIP_EN
    ch_en  = 4'hf;
    ch_en3 = 3'b111;
`endif
    #1 resetn = 1'b0;
    #1;
    chk("reset.data_out", 32'(dout), 32'h0);
    chk_main("reset", 2'd0, 1'b0);
    tick(); tick();
    resetn = 1'b1;
    tick(); tick();
    chk("post_reset.data_out", 32'(dout), 32'h11);
    chk_main("post_reset", 2'd0, 1'b0);

    // Manual select 0 -> 3: cur_ch after one edge, data_out after two
    sel = 2'd3;
    tick();
    chk_main("man_sel3", 2'd3, 1'b1);
    chk("man_sel3.data_old", 32'(dout), 32'h11);
    tick();
    chk_main("man_sel3_b", 2'd3, 1'b0);
    chk("man_sel3.data", 32'(dout), 32'h44);
    din[31:24] = 8'h55;
    tick();
    chk("man_data_lat", 32'(dout), 32'h55);
    chk("man_resel.ch_change", 32'(chg), 32'h0);
    din[31:24] = 8'h44;

    // Scan from channel 0: 1,2,3,0 with three clocks per channel
    sel = 2'd0;
    tick();
    chk_main("man_sel0", 2'd0, 1'b1);
    mode = 1'b1;
    tick();
    chk_main("scan_enter", 2'd0, 1'b0);
    c = 2'd0;
    for (int s = 0; s < 4; s++) begin
      tick();
      chk_main("scan_d1", c, 1'b0);
      chk("scan_d1.data", 32'(dout), 32'(dtab[c]));
      tick();
      chk_main("scan_d2", c, 1'b0);
      tick();
      chk_main("scan_adv", c + 2'd1, 1'b1);
      c = c + 2'd1;
    end

    // Hold at count 1 for five clocks; advance comes two clocks after release
    tick();
    chk("pre_hold.data", 32'(dout), 32'h11);
    hold = 1'b1;
    din[7:0] = 8'h5a;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_main("hold", 2'd0, 1'b0);
      chk("hold.data", 32'(dout), 32'h5a);
    end
    hold = 1'b0;
    din[7:0] = 8'h11;
    tick();
    chk_main("hold_rel1", 2'd0, 1'b0);
    tick();
    chk_main("hold_rel2", 2'd1, 1'b1);

    // Advance to channel 2, then reset asynchronously mid-dwell
    tick(); tick(); tick();
    chk_main("to_ch2", 2'd2, 1'b1);
    tick();
    #2 resetn = 1'b0;
    #1;
    chk("async_reset.data_out", 32'(dout), 32'h0);
    chk_main("async_reset", 2'd0, 1'b0);
    mode = 1'b0;
    sel  = 2'd0;
    tick();
    resetn = 1'b1;
    tick();
    chk("release.data_out", 32'(dout), 32'h11);
    chk_main("release", 2'd0, 1'b0);

    // Leave scan in the wrap cycle: no advance, then manual select of 2
    mode = 1'b1;
    tick(); tick(); tick();
    chk_main("scan_cnt2", 2'd0, 1'b0);
    mode = 1'b0;
    sel  = 2'd2;
    tick();
    chk_main("exit_wrap", 2'd0, 1'b0);
    tick();
    chk_main("exit_sel2", 2'd2, 1'b1);
    tick();
    chk_main("exit_after", 2'd2, 1'b0);
    chk("exit.data", 32'(dout), 32'h33);

    // Three channels, DWELL=1: out-of-range select ignored, wrap 2 -> 0 each clock
    sel3 = 2'd1;
    tick();
    chk("c3_sel1.cur_ch", 32'(cur3), 32'd1);
    sel3 = 2'd3;
    tick();
    chk("c3_oor.cur_ch", 32'(cur3), 32'd1);
    chk("c3_oor.ch_change", 32'(chg3), 32'd0);
    chk("c3_oor.data", 32'(dout3), 32'h66);
    mode3 = 1'b1;
    tick();
    chk("c3_enter.cur_ch", 32'(cur3), 32'd1);
    tick();
    chk("c3_adv2.cur_ch", 32'(cur3), 32'd2);
    chk("c3_adv2.ch_change", 32'(chg3), 32'd1);
    tick();
    chk("c3_wrap.cur_ch", 32'(cur3), 32'd0);
    chk("c3_wrap.ch_change", 32'(chg3), 32'd1);
    chk("c3_wrap.data", 32'(dout3), 32'h77);
    hold3 = 1'b1;
    tick();
    chk("c3_hold.cur_ch", 32'(cur3), 32'd0);
    chk("c3_hold.ch_change", 32'(chg3), 32'd0);

`ifdef SCAN_MUX_SKIP_EN
    // Only channels 1 and 3 enabled
    ch_en = 4'b1010;
    sel = 2'd1;
    tick();
    chk_main("skip_sel1", 2'd1, 1'b1);
    sel = 2'd0;
    tick();
    chk_main("skip_sel_dis", 2'd1, 1'b0);
    mode = 1'b1;
    tick();
    chk_main("skip_enter", 2'd1, 1'b0);
    seq6[0] = 2'd3; seq6[1] = 2'd1; seq6[2] = 2'd3; seq6[3] = 2'd1;
    c = 2'd1;
    for (int s = 0; s < 4; s++) begin
      tick();
      chk_main("skip_d1", c, 1'b0);
      tick();
      chk_main("skip_d2", c, 1'b0);
      tick();
      chk_main("skip_adv", seq6[s], 1'b1);
      c = seq6[s];
    end
    ch_en = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_main("skip_none", 2'd1, 1'b0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
